// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and arbiter for the single shared memory port.
// A write to DMA_REG_ADDR copies DMA_LEN bytes from {src_hi,8'h00} into OAM, one byte per M-cycle.
module oam_dma_arbiter #(
    parameter int                   DATA_SIZE    = 8,
    parameter int                   ADDR_SIZE    = 16,
    parameter logic [ADDR_SIZE-1:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [ADDR_SIZE-1:0] DEST_BASE    = 16'hFE00,
    parameter int                   DMA_LEN      = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_tick,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [DATA_SIZE-1:0] cpu_wdata,
    output logic [DATA_SIZE-1:0] cpu_rdata,
    output logic                 cpu_wait,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 dma_active
);

    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RD, S_WR, S_WAIT} state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t               state, state_n;
    logic [7:0]           idx, idx_n;
    logic [DATA_SIZE-1:0] src_hi, src_hi_n;
    logic [DATA_SIZE-1:0] src_eff;
    logic [DATA_SIZE-1:0] buffer;
    logic                 delay_seen, delay_seen_n;
    logic                 reg_hit, trigger, permitted, dma_owns;

    assign reg_hit    = (cpu_addr == DMA_REG_ADDR);
    assign trigger    = cpu_wr && reg_hit;
    assign dma_active = (state != S_IDLE);
    assign dma_owns   = (state == S_RD) || (state == S_WR);
    assign permitted  = !dma_active || (cpu_addr[ADDR_SIZE-1:8] == '1);
    // Echo-RAM pages E0..FF fold back onto C0..DF.
    assign src_eff    = (src_hi >= 8'hE0) ? src_hi - 8'h20 : src_hi;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            src_hi     <= 8'hFF;
            delay_seen <= 1'b0;
            buffer     <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            src_hi     <= src_hi_n;
            delay_seen <= delay_seen_n;
            if (state == S_RD) buffer <= mem_rdata;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        src_hi_n     = src_hi;
        delay_seen_n = delay_seen;
        if (trigger) begin
            // A register write restarts from any state, beating a coincident m_tick.
            state_n      = S_DELAY;
            idx_n        = '0;
            src_hi_n     = cpu_wdata;
            delay_seen_n = 1'b0;
        end else begin
            case (state)
                S_DELAY: if (m_tick) begin
                    if (delay_seen) state_n = S_RD;
                    else            delay_seen_n = 1'b1;
                end
                S_RD:    state_n = S_WR;
                S_WR: begin
                    if (idx == LAST_IDX) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_WAIT;
                        idx_n   = idx + 8'd1;
                    end
                end
                S_WAIT:  if (m_tick) state_n = S_RD;
                default: state_n = state;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        cpu_rdata = '0;
        cpu_wait  = 1'b0;
        // The CPU pass-through is combinational, so reset must also mask it.
        if (rst) begin
            if (state == S_RD) begin
                mem_addr = {src_eff, idx};
                mem_rd   = 1'b1;
            end else if (state == S_WR) begin
                mem_addr  = DEST_BASE + ADDR_SIZE'(idx);
                mem_wr    = 1'b1;
                mem_wdata = buffer;
            end

            if (reg_hit) begin
                cpu_rdata = src_hi;
            end else if (!permitted) begin
                cpu_rdata = 8'hFF;
            end else if (dma_owns) begin
                cpu_wait = cpu_rd || cpu_wr;
            end else begin
                mem_addr  = cpu_addr;
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
                mem_wdata = cpu_wdata;
                cpu_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: 64 KiB memory model, M-cycle tick generator,
// and a reference that predicts OAM contents from the source page rules.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_tick = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    logic [1:0]  tcnt = '0;

    logic [7:0]  exp_oam [0:159];
    logic [7:0]  old_oam [0:159];

    int vectors = 0;
    int errors = 0;
    int oam_writes = 0;
    int active_ticks = 0;

    oam_dma_arbiter dut (
        .clk(clk), .rst(rst), .m_tick(m_tick),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pl_en)       mem[pl_addr] <= pl_data;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_wr && mem_addr >= 16'hFE00 && mem_addr <= 16'hFE9F) oam_writes <= oam_writes + 1;
        if (m_tick && dma_active) active_ticks <= active_ticks + 1;
    end

    // One M-cycle = four clocks; m_tick marks the last one.
    initial forever begin
        @(posedge clk);
        #1;
        tcnt   = tcnt + 2'd1;
        m_tick = (tcnt == 2'd3);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Backdoor preload through the memory model's own write port; xor_mode writes i^8'h5A.
    task automatic fill(input logic [15:0] base, input int n, input bit xor_mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pl_en   = 1'b1;
            pl_addr = base + 16'(i);
            pl_data = xor_mode ? (8'(i) ^ 8'h5A) : 8'($urandom);
        end
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic cpu_access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                              output logic [7:0] q, output int waits);
        waits = 0;
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rd    = !is_wr;
        cpu_wr    = is_wr;
        @(negedge clk);
        while (cpu_wait && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        q = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // Reference: OAM receives DMA_LEN bytes of the effective source page.
    task automatic model_transfer(input logic [7:0] hi);
        logic [7:0] page;
        page = (hi >= 8'hE0) ? hi - 8'h20 : hi;
        for (int i = 0; i < 160; i++) exp_oam[i] = mem[{page, 8'(i)}];
    endtask

    task automatic wait_done(output logic [15:0] first_wr, output bit to);
        int  cyc;
        bit  got;
        cyc = 0;
        got = 1'b0;
        first_wr = '0;
        to = 1'b0;
        forever begin
            @(negedge clk);
            if (!dma_active) break;
            if (mem_wr && !got) begin
                got = 1'b1;
                first_wr = mem_addr;
            end
            cyc++;
            if (cyc > 2000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_oam(input int target, output bit to);
        int cyc;
        cyc = 0;
        to = 1'b0;
        while (oam_writes < target) begin
            @(negedge clk);
            cyc++;
            if (cyc > 2000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] q;
        int w;
        cpu_addr = 16'h1234;
        cpu_rd   = 1'b1;
        #12;
        vectors++;
        if ({mem_addr, mem_rd, mem_wr, mem_wdata, cpu_rdata, cpu_wait, dma_active} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h rd=%b wr=%b wdata=%h rdata=%h wait=%b act=%b expected all zero",
                     mem_addr, mem_rd, mem_wr, mem_wdata, cpu_rdata, cpu_wait, dma_active);
        end
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (dma_active !== 1'b0 || mem_wr !== 1'b0 || cpu_wait !== 1'b0) begin
            errors++;
            $display("FAIL idle_flags: got act=%b wr=%b wait=%b expected 0 0 0", dma_active, mem_wr, cpu_wait);
        end
        cpu_access(1'b0, 16'hFF46, 8'h00, q, w);
        vectors++;
        if (q !== 8'hFF) begin
            errors++;
            $display("FAIL reg_reset_read: got %h expected ff", q);
        end
        cpu_access(1'b1, 16'h8000, 8'hA5, q, w);
        cpu_access(1'b0, 16'h8000, 8'h00, q, w);
        vectors++;
        if (q !== 8'hA5 || mem[16'h8000] !== 8'hA5 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL idle_passthrough: got rd=%h mem=%h act=%b expected a5 a5 0", q, mem[16'h8000], dma_active);
        end
    endtask

    task automatic test_full_copy();
        logic [7:0]  q, fea0;
        logic [15:0] fw;
        int w, t0;
        bit to;
        fill(16'hC000, 160, 1'b1);
        fill(16'hFE00, 161, 1'b0);
        fea0 = mem[16'hFEA0];
        model_transfer(8'hC0);
        cpu_access(1'b1, 16'hFF46, 8'hC0, q, w);
        t0 = active_ticks;
        wait_done(fw, to);
        vectors++;
        if (to || active_ticks - t0 != 161) begin
            errors++;
            $display("FAIL full_ticks: got %0d (timeout=%b) expected 161", active_ticks - t0, to);
        end
        for (int i = 0; i < 160; i++) begin
            vectors++;
            if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) begin
                errors++;
                $display("FAIL full_copy[%0d]: got %h expected %h", i, mem[16'hFE00 + 16'(i)], exp_oam[i]);
            end
        end
        vectors++;
        if (mem[16'hFEA0] !== fea0) begin
            errors++;
            $display("FAIL fea0_untouched: got %h expected %h", mem[16'hFEA0], fea0);
        end
    endtask

    task automatic test_cpu_during_dma();
        logic [7:0]  q, c050, exp_q;
        logic [15:0] fw, a;
        int w, t0;
        bit to, saw_wait;
        fill(16'hC000, 160, 1'b0);
        fill(16'hFF80, 16, 1'b0);
        c050 = mem[16'hC050];
        model_transfer(8'hC0);
        cpu_access(1'b1, 16'hFF46, 8'hC0, q, w);
        t0 = active_ticks;
        cpu_access(1'b0, 16'h1234, 8'h00, q, w);
        vectors++;
        if (q !== 8'hFF || w != 0) begin
            errors++;
            $display("FAIL blocked_read: got %h waits=%0d expected ff waits=0", q, w);
        end
        cpu_access(1'b1, 16'hC050, 8'h77, q, w);
        cpu_access(1'b1, 16'hFF90, 8'h3C, q, w);
        cpu_access(1'b0, 16'hFF46, 8'h00, q, w);
        vectors++;
        if (q !== 8'hC0) begin
            errors++;
            $display("FAIL reg_read_active: got %h expected c0", q);
        end
        saw_wait = 1'b0;
        for (int k = 0; k < 64 && !saw_wait; k++) begin
            a = 16'hFF80 + 16'($urandom_range(0, 15));
            exp_q = mem[a];
            cpu_access(1'b0, a, 8'h00, q, w);
            if (w > 0) saw_wait = 1'b1;
            vectors++;
            if (q !== exp_q || w > 2) begin
                errors++;
                $display("FAIL hram_read %h: got %h waits=%0d expected %h waits<=2", a, q, w, exp_q);
            end
        end
        vectors++;
        if (!saw_wait) begin
            errors++;
            $display("FAIL wait_seen: got no cpu_wait expected at least one");
        end
        wait_done(fw, to);
        vectors++;
        if (to || active_ticks - t0 != 161) begin
            errors++;
            $display("FAIL busy_ticks: got %0d (timeout=%b) expected 161", active_ticks - t0, to);
        end
        vectors++;
        if (mem[16'hFF90] !== 8'h3C || mem[16'hC050] !== c050) begin
            errors++;
            $display("FAIL cpu_side_writes: got ff90=%h c050=%h expected 3c %h", mem[16'hFF90], mem[16'hC050], c050);
        end
        for (int i = 0; i < 160; i++) begin
            vectors++;
            if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) begin
                errors++;
                $display("FAIL busy_copy[%0d]: got %h expected %h", i, mem[16'hFE00 + 16'(i)], exp_oam[i]);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [7:0]  q;
        logic [15:0] fw;
        int w, w0, t0;
        bit to;
        fill(16'hC000, 160, 1'b0);
        fill(16'hD000, 160, 1'b0);
        w0 = oam_writes;
        cpu_access(1'b1, 16'hFF46, 8'hC0, q, w);
        wait_oam(w0 + 80, to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL retrig_first_half: got %0d writes expected 80", oam_writes - w0);
        end
        model_transfer(8'hD0);
        cpu_access(1'b1, 16'hFF46, 8'hD0, q, w);
        t0 = active_ticks;
        wait_done(fw, to);
        vectors++;
        if (to || active_ticks - t0 != 161) begin
            errors++;
            $display("FAIL retrig_ticks: got %0d (timeout=%b) expected 161", active_ticks - t0, to);
        end
        vectors++;
        if (fw !== 16'hFE00) begin
            errors++;
            $display("FAIL retrig_restart_addr: got %h expected fe00", fw);
        end
        for (int i = 0; i < 160; i++) begin
            vectors++;
            if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) begin
                errors++;
                $display("FAIL retrig_copy[%0d]: got %h expected %h", i, mem[16'hFE00 + 16'(i)], exp_oam[i]);
            end
        end
    endtask

    task automatic test_echo_page();
        logic [7:0]  q;
        logic [15:0] fw;
        int w;
        bit to;
        fill(16'hC100, 160, 1'b0);
        fill(16'hE100, 160, 1'b0);
        model_transfer(8'hE1);
        cpu_access(1'b1, 16'hFF46, 8'hE1, q, w);
        cpu_access(1'b0, 16'hFF46, 8'h00, q, w);
        vectors++;
        if (q !== 8'hE1) begin
            errors++;
            $display("FAIL echo_reg_read: got %h expected e1", q);
        end
        wait_done(fw, to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL echo_done: got timeout expected completion");
        end
        for (int i = 0; i < 160; i++) begin
            vectors++;
            if (mem[16'hFE00 + 16'(i)] !== exp_oam[i]) begin
                errors++;
                $display("FAIL echo_copy[%0d]: got %h expected %h", i, mem[16'hFE00 + 16'(i)], exp_oam[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q;
        int w, w0, w1;
        bit to;
        fill(16'hC000, 160, 1'b0);
        for (int i = 0; i < 160; i++) old_oam[i] = mem[16'hFE00 + 16'(i)];
        model_transfer(8'hC0);
        w0 = oam_writes;
        cpu_access(1'b1, 16'hFF46, 8'hC0, q, w);
        wait_oam(w0 + 40, to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL mid_progress: got %0d writes expected 40", oam_writes - w0);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({mem_addr, mem_rd, mem_wr, mem_wdata, cpu_rdata, cpu_wait, dma_active} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got addr=%h rd=%b wr=%b act=%b expected all zero",
                     mem_addr, mem_rd, mem_wr, dma_active);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        w1 = oam_writes;
        repeat (200) @(posedge clk);
        #1;
        vectors++;
        if (oam_writes != w1 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d writes act=%b expected 0 writes act=0", oam_writes - w1, dma_active);
        end
        for (int i = 0; i < 160; i++) begin
            vectors++;
            if (mem[16'hFE00 + 16'(i)] !== ((i < 40) ? exp_oam[i] : old_oam[i])) begin
                errors++;
                $display("FAIL mid_oam[%0d]: got %h expected %h", i, mem[16'hFE00 + 16'(i)],
                         (i < 40) ? exp_oam[i] : old_oam[i]);
            end
        end
        cpu_access(1'b0, 16'hFF46, 8'h00, q, w);
        vectors++;
        if (q !== 8'hFF) begin
            errors++;
            $display("FAIL mid_reg_reset: got %h expected ff", q);
        end
    endtask

    initial begin
        test_reset();
        test_full_copy();
        test_cpu_during_dma();
        test_retrigger();
        test_echo_page();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
